// File: rtl/calc1.sv
// Exponent-path select encoding shared with calculation_unit.
package calc1;

  typedef enum logic [1:0] {
    EXP_ALIGNED_A   = 2'd0,
    EXP_ADDER       = 2'd1,
    EXP_SUBTRACTOR  = 2'd2
  } exponent_select;

endpackage

// File: rtl/calc2.sv
// Fraction-path select encoding shared with calculation_unit.
package calc2;

  typedef enum logic [1:0] {
    FRAC_ADDER         = 2'd0,
    FRAC_SUBTRACTOR    = 2'd1,
    FRAC_MULTIPLIER    = 2'd2,
    FRAC_QUOTIENT_ROOT = 2'd3
  } fraction_select;

endpackage

// File: rtl/calc_ctrl.sv
// Operation, state and select-decode definitions for calculation_unit_controller.
package calc_ctrl;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_SQRT = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_ITERATE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  typedef struct packed {
    calc1::exponent_select exponent;
    calc2::fraction_select fraction;
    logic                  mode;
  } decode_t;

  // Reserved encodings collapse to ADD.
  function automatic op_t legal_op(input op_t op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SQRT: return op;
      default:                                 return OP_ADD;
    endcase
  endfunction

  function automatic logic is_iterative(input op_t op);
    return (op == OP_DIV) || (op == OP_SQRT);
  endfunction

  function automatic decode_t decode(input op_t op);
    decode_t d;
    d.exponent = calc1::EXP_ALIGNED_A;
    d.fraction = calc2::FRAC_ADDER;
    d.mode     = 1'b0;
    case (op)
      OP_SUB: d.fraction = calc2::FRAC_SUBTRACTOR;
      OP_MUL: begin
        d.exponent = calc1::EXP_ADDER;
        d.fraction = calc2::FRAC_MULTIPLIER;
      end
      OP_DIV: begin
        d.exponent = calc1::EXP_SUBTRACTOR;
        d.fraction = calc2::FRAC_QUOTIENT_ROOT;
      end
      OP_SQRT: begin
        d.fraction = calc2::FRAC_QUOTIENT_ROOT;
        d.mode     = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/calc_ctrl_watchdog.sv
// Iteration watchdog: counts enabled cycles, flags the last allowed cycle.
module calc_ctrl_watchdog #(
  parameter int unsigned MAX_CYCLES = 40,
  parameter int unsigned CNT_W      = $clog2(MAX_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // Asserted in the cycle whose increment would reach MAX_CYCLES.
  assign expired = enable && (count == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/calculation_unit_controller.sv
// Sequencing controller for calculation_unit: op handshake, select decode,
// divide/sqrt iteration with watchdog, and result hold until accepted.
module calculation_unit_controller
  import calc_ctrl::*;
#(
  parameter int unsigned MAX_ITER_CYCLES = 40,
  parameter int unsigned CNT_W           = $clog2(MAX_ITER_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  op_t                   in_op,
  output logic                  in_ready,
  input  logic                  done,
  output calc1::exponent_select calculation_exponent_select,
  output calc2::fraction_select calculation_fraction_select,
  output logic                  division_mode,
  output logic                  division_op,
  output logic                  result_load,
  output logic                  out_valid,
  output logic                  out_error,
  input  logic                  out_ready,
  output logic                  busy
);

  state_t  state;
  op_t     op_q;
  op_t     new_op;
  logic    err_q;
  logic    mode_q;
  logic    accept;
  logic    expired;
  logic    is_idle;
  logic    is_iter;
  logic    is_hold;
  decode_t cur_dec;

  assign is_idle = (state == ST_IDLE);
  assign is_iter = (state == ST_ITERATE);
  assign is_hold = (state == ST_HOLD);

  assign new_op   = legal_op(in_op);
  assign cur_dec  = decode(op_q);
  assign in_ready = is_idle || (is_hold && out_ready);
  assign accept   = in_valid && in_ready;

  assign calculation_exponent_select = cur_dec.exponent;
  assign calculation_fraction_select = cur_dec.fraction;

  // Mode follows the op while iterating and holds its last value otherwise.
  assign division_mode = is_iter ? cur_dec.mode : mode_q;

  // done drops the start/hold line in the same cycle so the unit never restarts.
  assign division_op = !reset && is_iter && !done && !expired;
  assign result_load = !reset && ((state == ST_EXEC) || (is_iter && done));

  assign busy      = !is_idle;
  assign out_valid = is_hold;
  assign out_error = is_hold && err_q;

  calc_ctrl_watchdog #(
    .MAX_CYCLES (MAX_ITER_CYCLES),
    .CNT_W      (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .enable  (is_iter),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      op_q   <= OP_ADD;
      err_q  <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      mode_q <= division_mode;
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            op_q  <= new_op;
            err_q <= 1'b0;
            state <= is_iterative(new_op) ? ST_ITERATE : ST_EXEC;
          end else if (is_hold && out_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_EXEC: state <= ST_HOLD;
        ST_ITERATE: begin
          // done takes priority over a simultaneous watchdog expiry.
          if (done) begin
            state <= ST_HOLD;
          end else if (expired) begin
            state <= ST_HOLD;
            err_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calculation_unit_controller.sv
// Randomized self-checking bench for calculation_unit_controller.
module tb_calculation_unit_controller;
  import calc_ctrl::*;

  localparam int unsigned MAX_ITER = 40;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  op_t  in_op;
  logic in_ready;
  logic done;
  calc1::exponent_select exp_sel;
  calc2::fraction_select frac_sel;
  logic division_mode;
  logic division_op;
  logic result_load;
  logic out_valid;
  logic out_error;
  logic out_ready;
  logic busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  calculation_unit_controller #(.MAX_ITER_CYCLES(MAX_ITER)) dut (
    .clk                         (clk),
    .reset                       (reset),
    .in_valid                    (in_valid),
    .in_op                       (in_op),
    .in_ready                    (in_ready),
    .done                        (done),
    .calculation_exponent_select (exp_sel),
    .calculation_fraction_select (frac_sel),
    .division_mode               (division_mode),
    .division_op                 (division_op),
    .result_load                 (result_load),
    .out_valid                   (out_valid),
    .out_error                   (out_error),
    .out_ready                   (out_ready),
    .busy                        (busy)
  );

  // Reference select table by raw op code (codes 5..7 behave as ADD).
  function automatic calc1::exponent_select ref_exp(input int op);
    case (op)
      2:       return calc1::EXP_ADDER;
      3:       return calc1::EXP_SUBTRACTOR;
      default: return calc1::EXP_ALIGNED_A;
    endcase
  endfunction

  function automatic calc2::fraction_select ref_frac(input int op);
    case (op)
      1:       return calc2::FRAC_SUBTRACTOR;
      2:       return calc2::FRAC_MULTIPLIER;
      3, 4:    return calc2::FRAC_QUOTIENT_ROOT;
      default: return calc2::FRAC_ADDER;
    endcase
  endfunction

  function automatic op_t to_op(input int code);
    return op_t'(3'(code));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] want;
    reset = 1'b1; in_valid = 1'b0; in_op = OP_ADD; done = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      done = 1'b1;
      #3;
      tests++;
      if (division_op !== 1'b0) begin
        fails++;
        $display("FAIL reset_divop cyc%0d: got %b want 0", c, division_op);
      end
      tick();
    end
    reset = 1'b0; done = 1'b0;
    want = {1'b1, 6'b0, 2'(calc1::EXP_ALIGNED_A), 2'(calc2::FRAC_ADDER)};
    for (int c = 0; c < 5; c++) begin
      #3;
      tests++;
      if ({in_ready, busy, division_op, result_load, out_valid, out_error, division_mode,
           exp_sel, frac_sel} !== want) begin
        fails++;
        $display("FAIL reset_idle cyc%0d: got %b want %b", c,
                 {in_ready, busy, division_op, result_load, out_valid, out_error,
                  division_mode, exp_sel, frac_sel}, want);
      end
      tick();
    end
  endtask

  task automatic test_single_cycle(input int n);
    int codes[6] = '{0, 1, 2, 5, 6, 7};
    int op;
    for (int k = 0; k < n; k++) begin
      op = codes[$urandom_range(0, 5)];
      in_valid = 1'b1; in_op = to_op(op);
      out_ready = 1'(($urandom_range(0, 1))); done = 1'(($urandom_range(0, 1)));
      #3;
      tests++;
      if ({in_ready, result_load, out_valid, busy} !== 4'b1000) begin
        fails++;
        $display("FAIL single_accept op%0d: got %b want 1000", op,
                 {in_ready, result_load, out_valid, busy});
      end
      tick();
      in_valid = 1'(($urandom_range(0, 1))); in_op = to_op($urandom_range(0, 7));
      done = 1'(($urandom_range(0, 1)));
      #3;
      tests++;
      if ({result_load, out_valid, busy, in_ready, division_op, exp_sel, frac_sel} !==
          {5'b10100, ref_exp(op), ref_frac(op)}) begin
        fails++;
        $display("FAIL single_exec op%0d: got %b want %b", op,
                 {result_load, out_valid, busy, in_ready, division_op, exp_sel, frac_sel},
                 {5'b10100, ref_exp(op), ref_frac(op)});
      end
      tick();
      in_valid = 1'b0; out_ready = 1'b1; done = 1'(($urandom_range(0, 1)));
      #3;
      tests++;
      if ({out_valid, out_error, result_load, in_ready, exp_sel, frac_sel} !==
          {4'b1001, ref_exp(op), ref_frac(op)}) begin
        fails++;
        $display("FAIL single_hold op%0d: got %b want %b", op,
                 {out_valid, out_error, result_load, in_ready, exp_sel, frac_sel},
                 {4'b1001, ref_exp(op), ref_frac(op)});
      end
      tick();
      out_ready = 1'b0; done = 1'b0;
    end
  endtask

  task automatic test_back_to_back(input int n);
    int ops[$];
    for (int k = 0; k < n; k++) ops.push_back($urandom_range(0, 2));
    in_valid = 1'b1; in_op = to_op(ops[0]); out_ready = 1'b1; done = 1'b0;
    tick();
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      #3;
      tests++;
      if ({result_load, out_valid, exp_sel, frac_sel} !== {2'b10, ref_exp(ops[k]), ref_frac(ops[k])}) begin
        fails++;
        $display("FAIL b2b_exec k%0d: got %b want %b", k,
                 {result_load, out_valid, exp_sel, frac_sel},
                 {2'b10, ref_exp(ops[k]), ref_frac(ops[k])});
      end
      tick();
      in_valid = (k < n - 1);
      if (k < n - 1) in_op = to_op(ops[k + 1]);
      #3;
      tests++;
      if ({out_valid, in_ready, result_load, exp_sel, frac_sel} !==
          {3'b110, ref_exp(ops[k]), ref_frac(ops[k])}) begin
        fails++;
        $display("FAIL b2b_hold k%0d: got %b want %b", k,
                 {out_valid, in_ready, result_load, exp_sel, frac_sel},
                 {3'b110, ref_exp(ops[k]), ref_frac(ops[k])});
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #3;
    tests++;
    if ({busy, out_valid} !== 2'b00) begin
      fails++;
      $display("FAIL b2b_idle: got %b want 00", {busy, out_valid});
    end
    tick();
  endtask

  // One divide/sqrt transaction; d is the ITERATE cycle (1-based) raising done, 0 = never.
  task automatic test_iterative_txn(input int op, input int d, input int stall);
    int   end_c;
    logic ok;
    int   hi_cnt;
    int   loads;
    logic sq;
    ok     = (d != 0) && (d <= int'(MAX_ITER));
    end_c  = ok ? d : int'(MAX_ITER);
    hi_cnt = 0;
    loads  = 0;
    sq     = (op == 4);
    in_valid = 1'b1; in_op = to_op(op); out_ready = 1'b0; done = 1'(($urandom_range(0, 1)));
    #3;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL iter_accept op%0d: got %b want 1", op, in_ready);
    end
    tick();
    for (int i = 1; i <= end_c; i++) begin
      in_valid = 1'(($urandom_range(0, 1))); in_op = to_op($urandom_range(0, 7));
      done = (i == d);
      #3;
      hi_cnt += int'(division_op);
      loads  += int'(result_load);
      tests++;
      if ({division_op, result_load, busy, division_mode, out_valid, exp_sel, frac_sel} !==
          {(i < end_c), (i == end_c) && ok, 1'b1, sq, 1'b0, ref_exp(op), ref_frac(op)}) begin
        fails++;
        $display("FAIL iter_cycle op%0d d%0d i%0d: got %b want %b", op, d, i,
                 {division_op, result_load, busy, division_mode, out_valid, exp_sel, frac_sel},
                 {(i < end_c), (i == end_c) && ok, 1'b1, sq, 1'b0, ref_exp(op), ref_frac(op)});
      end
      tick();
    end
    tests++;
    if (hi_cnt != end_c - 1 || loads != int'(ok)) begin
      fails++;
      $display("FAIL iter_totals op%0d d%0d: got divop=%0d loads=%0d want divop=%0d loads=%0d",
               op, d, hi_cnt, loads, end_c - 1, int'(ok));
    end
    in_valid = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      out_ready = (s == stall); done = 1'(($urandom_range(0, 1)));
      #3;
      tests++;
      if ({out_valid, out_error, in_ready, result_load, division_op, division_mode} !==
          {1'b1, !ok, (s == stall), 2'b00, sq}) begin
        fails++;
        $display("FAIL iter_hold op%0d d%0d s%0d: got %b want %b", op, d, s,
                 {out_valid, out_error, in_ready, result_load, division_op, division_mode},
                 {1'b1, !ok, (s == stall), 2'b00, sq});
      end
      tick();
    end
    out_ready = 1'b0; done = 1'b0;
    #3;
    tests++;
    if ({busy, out_valid, out_error} !== 3'b000) begin
      fails++;
      $display("FAIL iter_idle op%0d: got %b want 000", op, {busy, out_valid, out_error});
    end
    tick();
  endtask

  task automatic test_div_sqrt(input int n_rand);
    test_iterative_txn(3, 28, 0);
    test_iterative_txn(4, 0, 3);
    test_iterative_txn(4, 40, 1);
    test_iterative_txn(3, 39, 0);
    test_iterative_txn(3, 41, 2);
    test_iterative_txn(3, 1, 0);
    for (int k = 0; k < n_rand; k++)
      test_iterative_txn($urandom_range(3, 4), $urandom_range(0, 45), $urandom_range(0, 3));
  endtask

  task automatic test_stall();
    in_valid = 1'b1; in_op = OP_ADD; out_ready = 1'b0; done = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    for (int s = 0; s < 10; s++) begin
      in_valid = 1'(($urandom_range(0, 1))); in_op = to_op($urandom_range(0, 7));
      #3;
      tests++;
      if ({out_valid, out_error, in_ready, result_load, exp_sel, frac_sel} !==
          {4'b1000, ref_exp(0), ref_frac(0)}) begin
        fails++;
        $display("FAIL stall_hold s%0d: got %b want %b", s,
                 {out_valid, out_error, in_ready, result_load, exp_sel, frac_sel},
                 {4'b1000, ref_exp(0), ref_frac(0)});
      end
      tick();
    end
    in_valid = 1'b1; in_op = OP_MUL; out_ready = 1'b1;
    #3;
    tests++;
    if ({in_ready, out_valid, exp_sel, frac_sel} !== {2'b11, ref_exp(0), ref_frac(0)}) begin
      fails++;
      $display("FAIL stall_release: got %b want %b", {in_ready, out_valid, exp_sel, frac_sel},
               {2'b11, ref_exp(0), ref_frac(0)});
    end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #3;
    tests++;
    if ({result_load, out_valid, exp_sel, frac_sel} !== {2'b10, ref_exp(2), ref_frac(2)}) begin
      fails++;
      $display("FAIL stall_mul_load: got %b want %b", {result_load, out_valid, exp_sel, frac_sel},
               {2'b10, ref_exp(2), ref_frac(2)});
    end
    tick();
    out_ready = 1'b1;
    #3;
    tests++;
    if ({out_valid, out_error} !== 2'b10) begin
      fails++;
      $display("FAIL stall_mul_hold: got %b want 10", {out_valid, out_error});
    end
    tick();
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_op = OP_SQRT; out_ready = 1'b0; done = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      reset = (i == 5);
      #3;
      tests++;
      if (division_op !== (i < 5)) begin
        fails++;
        $display("FAIL midreset_divop i%0d: got %b want %b", i, division_op, (i < 5));
      end
      tick();
    end
    reset = 1'b0; in_valid = 1'b1; in_op = OP_ADD;
    #3;
    tests++;
    if ({busy, in_ready, division_op, division_mode, out_valid} !== 5'b01000) begin
      fails++;
      $display("FAIL midreset_idle: got %b want 01000",
               {busy, in_ready, division_op, division_mode, out_valid});
    end
    tick();
    in_valid = 1'b0;
    #3;
    tests++;
    if ({result_load, exp_sel, frac_sel} !== {1'b1, ref_exp(0), ref_frac(0)}) begin
      fails++;
      $display("FAIL midreset_add_load: got %b want %b", {result_load, exp_sel, frac_sel},
               {1'b1, ref_exp(0), ref_frac(0)});
    end
    tick();
    out_ready = 1'b1;
    #3;
    tests++;
    if ({out_valid, out_error} !== 2'b10) begin
      fails++;
      $display("FAIL midreset_add_hold: got %b want 10", {out_valid, out_error});
    end
    tick();
    out_ready = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_single_cycle(20);
    test_back_to_back(8);
    test_div_sqrt(10);
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calculation_unit_controller.md
# calculation_unit_controller

Sequencing controller for `calculation_unit`. It accepts one operation at a time over a valid/ready handshake and drives the exponent/fraction select lines and the divide/sqrt start controls. For divide and sqrt it waits on the iterative unit's `done`. It raises `result_load` in the cycle the calculated exponent, fraction and remainder are valid, then holds the result until downstream accepts it. A watchdog counter bounds divide/sqrt duration.

## Interface
Parameters:
- `MAX_ITER_CYCLES`, default 40: ITERATE cycles allowed before timeout. Must be at least the unit's worst-case divide/sqrt latency (26 iterations plus overhead).
- `CNT_W`, default `$clog2(MAX_ITER_CYCLES+1)`: watchdog counter width.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: operation request valid.
- `in_op` in `calc_ctrl::op_t`: requested operation.
- `in_ready` out 1: controller can accept an operation.
- `done` in 1: from `calculation_unit`.
- `calculation_exponent_select` out `calc1::exponent_select`: to `calculation_unit`.
- `calculation_fraction_select` out `calc2::fraction_select`: to `calculation_unit`.
- `division_mode` out 1: 0 = divide, 1 = sqrt.
- `division_op` out 1: iterative start/hold, to `calculation_unit`.
- `result_load` out 1: one-cycle capture strobe for the downstream result register.
- `out_valid` out 1: result held and valid.
- `out_error` out 1: qualifies `out_valid`; set when the watchdog expired.
- `out_ready` in 1: downstream accepts the result.
- `busy` out 1: state other than IDLE.

## Operation
- States: IDLE, EXEC, ITERATE, HOLD. Reset and timeout-free default state is IDLE.
- IDLE: `in_ready`=1. On `in_valid` the op is registered into `op_q` and the watchdog is cleared.
  - ADD, SUB, MUL go to EXEC.
  - DIV, SQRT go to ITERATE.
- EXEC: `result_load`=1 for exactly one cycle, then HOLD.
- ITERATE:
  - `division_op`=1 and the counter increments each cycle.
  - When `done`=1: `division_op`=0 in that same cycle (combinational, so no restart), `result_load`=1, next state HOLD.
  - When the counter reaches `MAX_ITER_CYCLES` without `done`: `division_op`=0, no `result_load`, set `err_q`, next state HOLD.
  - If `done` arrives in the same cycle as timeout, `done` wins and the error is not set.
- HOLD: `out_valid`=1 and `out_error`=`err_q`.
  - `out_ready`=1 with `in_valid`=1: accept the new op in the same cycle (`in_ready`=1), clear `err_q`, go directly to EXEC or ITERATE.
  - `out_ready`=1 without `in_valid`: go to IDLE.
- `in_ready` = IDLE | (HOLD & `out_ready`).
- Select decode, from `op_q` (registered, so stable from EXEC/ITERATE through HOLD):
  - ADD: exponent = aligned A; fraction = adder.
  - SUB: exponent = aligned A; fraction = subtractor.
  - MUL: exponent = exponent adder; fraction = multiplier.
  - DIV: exponent = exponent subtractor; fraction = quotient_root; `division_mode`=0.
  - SQRT: exponent = aligned A; fraction = quotient_root; `division_mode`=1.
  - `division_mode` holds its value outside ITERATE.
- Unknown or reserved `in_op` values are treated as ADD.

## Timing
- Reset values:
  - state IDLE.
  - `op_q`=ADD; `err_q`=0; counter 0.
  - `division_op`=0, `result_load`=0, `out_valid`=0, `out_error`=0, `busy`=0, `in_ready`=1.
  - `division_mode`=0.
- Reset asserted mid-operation aborts at the next edge. The controller does not drive `division_op` while `reset` is high.
- ADD/SUB/MUL: accept at edge N, `result_load` in cycle N+1, `out_valid` from N+2.
- DIV/SQRT: `division_op` high from cycle N+1 through the cycle before `done`. `result_load` in the `done` cycle; `out_valid` on the following cycle.
- `out_valid` and `out_error` are stable while `out_ready`=0.
- Back-to-back throughput for single-cycle ops: one result per 2 cycles.
- `done` outside ITERATE is ignored.

## Structure
- New package `calc_ctrl`:
  - `op_t` (3-bit enum: ADD, SUB, MUL, DIV, SQRT).
  - `state_t` enum.
  - Decode function `op_t` → {`calc1::exponent_select`, `calc2::fraction_select`, mode}.
- One natural sub-module: `calc_ctrl_watchdog` (clear/enable counter with an `expired` compare).

## Test plan
- Reset, then idle: all outputs at their reset values and `in_ready`=1 for 5 cycles.
- ADD at cycle 0 with `out_ready`=1:
  - `result_load` at cycle 1 and `out_valid` at cycle 2.
  - Fraction select = adder, exponent select = aligned A.
- DIV with `done` at ITERATE cycle 28:
  - `division_op`=1 for 27 cycles and 0 in the `done` cycle.
  - `result_load` in the `done` cycle; `division_mode`=0; `out_error`=0.
- SQRT with `done` never asserted and `MAX_ITER_CYCLES`=40:
  - Timeout after 40 cycles, no `result_load`.
  - `out_valid`=1 with `out_error`=1.
  - `done` exactly at cycle 40 gives `out_error`=0.
- HOLD with `out_ready`=0 for 10 cycles, then `out_ready`=1 together with MUL `in_valid`:
  - Result stays held during the stall.
  - MUL is accepted in the same cycle and its `result_load` follows in the next cycle.
- `reset` asserted at ITERATE cycle 5: next cycle is IDLE with `division_op`=0, then a fresh ADD completes normally.
